// File: rtl/serial_cmp_ctrl_if.sv
// Requester-side handshake bundle for serial_cmp_ctrl: start/operands in, busy/done/result out.
// Latency: none, plain wires grouped for port connection.
// Backpressure: none; the requester must watch busy/done before issuing another start.
// Ports (master = requester, slave = serial_cmp_ctrl):
//   start, a, b            requester -> controller
//   busy, done, lt, eq, gt, nslc   controller -> requester
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int NW = $clog2(WIDTH / 2) + 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [NW-1:0]    nslc;

    modport master (
        output start, a, b,
        input  busy, done, lt, eq, gt, nslc
    );

    modport slave (
        input  start, a, b,
        output busy, done, lt, eq, gt, nslc
    );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude compare: walks 2-bit slices MSB-first through an external comparator, stops at the first unequal slice.
// Latency: k cycles from start edge to done (k = slices examined, 1..WIDTH/2); done lasts one cycle.
// Backpressure: start is only sampled in IDLE; held start yields one compare every k+2 cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req (slave modport)   start/a/b in, busy/done/lt/eq/gt/nslc out
//   slc_a, slc_b          current operand slices to the comparator (00 outside RUN)
//   cmp_lt/eq/gt          combinational comparator response for the presented slices
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_cmp_ctrl_if.slave   req,
    output logic [1:0]         slc_a,
    output logic [1:0]         slc_b,
    input  logic               cmp_lt,
    input  logic               cmp_eq,
    input  logic               cmp_gt
);
    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic             lt_r;
    logic             eq_r;
    logic             gt_r;
    logic [CW-1:0]    nslc_r;

    // lt is implied by "not equal and not greater", so the comparator's lt
    // output never enters the decision.
    logic unused_cmp_lt;
    assign unused_cmp_lt = cmp_lt;

    // Slices come straight off the shift registers; busy is high exactly in RUN.
    assign slc_a = busy_r ? sa[WIDTH-1 -: 2] : 2'b00;
    assign slc_b = busy_r ? sb[WIDTH-1 -: 2] : 2'b00;

    assign req.busy = busy_r;
    assign req.done = done_r;
    assign req.lt   = lt_r;
    assign req.eq   = eq_r;
    assign req.gt   = gt_r;
    assign req.nslc = nslc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            lt_r   <= 1'b0;
            eq_r   <= 1'b0;
            gt_r   <= 1'b0;
            nslc_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (req.start) begin
                        sa     <= req.a;
                        sb     <= req.b;
                        cnt    <= CW'(1);
                        lt_r   <= 1'b0;
                        eq_r   <= 1'b0;
                        gt_r   <= 1'b0;
                        nslc_r <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!cmp_eq) begin
                        // First differing slice settles the whole compare.
                        gt_r   <= cmp_gt;
                        lt_r   <= ~cmp_gt;
                        eq_r   <= 1'b0;
                        nslc_r <= cnt;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (cnt == CW'(N)) begin
                        gt_r   <= 1'b0;
                        lt_r   <= 1'b0;
                        eq_r   <= 1'b1;
                        nslc_r <= CW'(N);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        sa  <= sa << 2;
                        sb  <= sb << 2;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl with a behavioural 2-bit comparator attached.
// Expected results are queued at stimulus time; a monitor pops them on each done pulse.
module tb_serial_cmp_ctrl;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    typedef struct {
        logic lt;
        logic eq;
        logic gt;
        int   n;
        int   lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] slc_a;
    logic [1:0] slc_b;
    logic       cmp_lt;
    logic       cmp_eq;
    logic       cmp_gt;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cyc = 0;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;
    exp_t sb_q[$];
    int   done_cyc[$];

    serial_cmp_ctrl_if #(.WIDTH(WIDTH)) req();

    serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .slc_a  (slc_a),
        .slc_b  (slc_b),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt)
    );

    // Behavioural 2-bit magnitude comparator slice.
    assign cmp_lt = (slc_a <  slc_b);
    assign cmp_eq = (slc_a == slc_b);
    assign cmp_gt = (slc_a >  slc_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consistency checks every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req.busy && !busy_q)
                start_cyc = cyc;
            if (req.busy) begin
                chk("cmp_onehot", int'(cmp_lt) + int'(cmp_eq) + int'(cmp_gt), 1);
                chk("busy_done_excl", int'(req.done), 0);
            end
            if (req.done) begin
                chk("done_single", int'(done_q), 0);
                done_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_lt", int'(req.lt), int'(e.lt));
                    chk("res_eq", int'(req.eq), int'(e.eq));
                    chk("res_gt", int'(req.gt), int'(e.gt));
                    chk("res_nslc", int'(req.nslc), e.n);
                    chk("latency", cyc - start_cyc, e.lat);
                end
            end
        end
        busy_q = req.busy;
        done_q = req.done;
    end

    task automatic push_exp(input logic elt, input logic eeq, input logic egt, input int en);
        exp_t e;
        e.lt  = elt;
        e.eq  = eeq;
        e.gt  = egt;
        e.n   = en;
        e.lat = en;
        sb_q.push_back(e);
    endtask

    // One start pulse; operands are scrambled right after capture to show
    // they are not re-read; slices are checked every RUN cycle.
    task automatic do_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic elt, input logic eeq, input logic egt, input int en);
        int i;
        @(negedge clk);
        req.a = ta;
        req.b = tb_v;
        req.start = 1'b1;
        push_exp(elt, eeq, egt, en);
        @(negedge clk);
        req.start = 1'b0;
        req.a = ~ta;
        req.b = ~tb_v;
        i = 0;
        while (!req.done && i < N + 2) begin
            chk("busy_run", int'(req.busy), 1);
            if (i < N) begin
                chk("slc_a", int'(slc_a), int'(ta[WIDTH-1-2*i -: 2]));
                chk("slc_b", int'(slc_b), int'(tb_v[WIDTH-1-2*i -: 2]));
            end
            i++;
            @(negedge clk);
        end
        if (!req.done)
            chk("done_timeout", 0, 1);
        chk("slices_seen", i, en);
        @(negedge clk);
        chk("hold_lt", int'(req.lt), int'(elt));
        chk("hold_eq", int'(req.eq), int'(eeq));
        chk("hold_gt", int'(req.gt), int'(egt));
        chk("idle_busy", int'(req.busy), 0);
        chk("idle_slc_a", int'(slc_a), 0);
    endtask

    initial begin
        req.start = 1'b0;
        req.a = '0;
        req.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(req.busy), 0);
        chk("rst_done", int'(req.done), 0);
        chk("rst_lt", int'(req.lt), 0);
        chk("rst_eq", int'(req.eq), 0);
        chk("rst_gt", int'(req.gt), 0);
        chk("rst_nslc", int'(req.nslc), 0);
        chk("rst_slc_a", int'(slc_a), 0);
        chk("rst_slc_b", int'(slc_b), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmp(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 4);   // equal, full length
        do_cmp(8'hC0, 8'h40, 1'b0, 1'b0, 1'b1, 1);   // MSB slice 11 vs 01
        do_cmp(8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 4);   // LSB slice 10 vs 11
        do_cmp(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1);
        do_cmp(8'h5B, 8'h57, 1'b0, 1'b0, 1'b1, 3);   // 01/01 01/01 10/01

        // start held high: accepted at E0, E4, E8; operands disturbed while busy.
        done_cyc.delete();
        @(negedge clk);
        req.a = 8'h30;
        req.b = 8'h20;
        req.start = 1'b1;
        for (int c = 0; c < 3; c++) push_exp(1'b0, 1'b0, 1'b1, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hs_busy", int'(req.busy), 1);
            req.a = 8'h00;
            req.b = 8'hFF;
            @(negedge clk);
            req.a = 8'h30;
            req.b = 8'h20;
            @(negedge clk);
            @(negedge clk);
            if (c == 2) req.start = 1'b0;
        end
        chk("hs_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk("hs_gap0", done_cyc[1] - done_cyc[0], 4);
            chk("hs_gap1", done_cyc[2] - done_cyc[1], 4);
        end
        repeat (5) @(negedge clk);
        chk("hold_idle_gt", int'(req.gt), 1);
        chk("hold_idle_lt", int'(req.lt), 0);
        chk("hold_idle_eq", int'(req.eq), 0);
        chk("hold_idle_nslc", int'(req.nslc), 2);
        chk("hold_idle_busy", int'(req.busy), 0);

        // Reset mid-RUN at E2 of an a=01, b=02 compare (would finish at E4).
        @(negedge clk);
        req.a = 8'h01;
        req.b = 8'h02;
        req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(req.busy), 0);
        chk("arst_done", int'(req.done), 0);
        chk("arst_gt", int'(req.gt), 0);
        chk("arst_nslc", int'(req.nslc), 0);
        chk("arst_slc_a", int'(slc_a), 0);
        chk("arst_slc_b", int'(slc_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cyc.delete();
        repeat (4) @(negedge clk);
        chk("arst_no_done", done_cyc.size(), 0);
        do_cmp(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

Sequencer that compares two WIDTH-bit unsigned operands by driving the team's 2-bit magnitude comparator slice (a1/a2, b1/b2 in; lt/eq/gt out) one 2-bit slice per clock, MSB slice first. It stops at the first unequal slice. It sits between a requester using a start/done handshake and a single shared combinational 2-bit comparator instance, which is external to this block. The block owns only the slicing, the early-termination decision and the registered result.

## Interface
- WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 slices
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the start edge
- b  in  WIDTH  operand B; captured on the start edge
- slc_a  out  2  current A slice to comparator; slc_a[1] drives a1 (MSB), slc_a[0] drives a2
- slc_b  out  2  current B slice to comparator; slc_b[1] drives b1, slc_b[0] drives b2
- cmp_lt  in  1  comparator lt, combinational from slc_a/slc_b
- cmp_eq  in  1  comparator eq
- cmp_gt  in  1  comparator gt
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- lt, eq, gt  out  1 each  registered result; one-hot after a completion
- nslc  out  $clog2(N)+1  number of slices examined for the last result (1..N)

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE
  - On start=1: load shift registers sa<=a and sb<=b, slice counter <= 1, and clear lt/eq/gt/nslc to 0. Go to RUN.
  - On start=0: stay in IDLE.
- RUN
  - slc_a = sa[WIDTH-1:WIDTH-2] and slc_b = sb[WIDTH-1:WIDTH-2], driven directly from the registers.
  - Each edge evaluates the comparator outputs as follows:
    - cmp_eq=0: gt<=cmp_gt, lt<=~cmp_gt, eq<=0, nslc<=counter. Go to DONE.
    - cmp_eq=1 and counter==N: eq<=1, lt<=0, gt<=0, nslc<=N. Go to DONE.
    - Otherwise: sa<=sa<<2, sb<=sb<<2, counter<=counter+1. Stay in RUN.
  - cmp_lt is not used in the decision. The bench checks it for consistency only.
- DONE
  - Lasts exactly one cycle with done=1. Unconditionally returns to IDLE.
  - start is ignored in DONE.
- start is ignored in RUN. Operands cannot be changed mid-compare.
- slc_a and slc_b are 2'b00 outside RUN.
- lt/eq/gt/nslc hold their value from the DONE entry until the next accepted start, which clears them.
- Reset values: busy=0, done=0, lt=0, eq=0, gt=0, nslc=0, slc_a=0, slc_b=0. Internal sa, sb and counter are 0.
- rst_n low at any time, including mid-RUN, asynchronously forces IDLE and all reset values. No done pulse is produced for the aborted compare.

## Timing
- E0 = edge at which start is accepted. Slice k (1..N) is presented during the cycle after E(k-1) and decided at edge Ek.
- Result and nslc are valid from edge Ek. done is high for the cycle Ek..E(k+1).
- Latency from start edge to done rising is k cycles. The best case is 1 cycle and the worst case is N cycles (equal operands, or a difference only in the LSB slice).
- busy rises at E0 and falls at Ek.
- The earliest next start is accepted at E(k+2), i.e. start held high gives one compare every k+2 cycles.
- The comparator path slc -> cmp_* -> next-state logic must close in one clock period. There is no pipelining of cmp_*.

## Test plan
All scenarios use WIDTH=8 with a behavioural 2-bit comparator attached.
- Equal operands: a=8'hA5, b=8'hA5, start pulse -> busy for 4 cycles, done at E4, eq=1, lt=0, gt=0, nslc=4.
- MSB-slice decision: a=8'hC0, b=8'h40 -> done at E1, gt=1, nslc=1, slc_a=2'b11 and slc_b=2'b01 during the single RUN cycle.
- LSB-slice decision: a=8'h12, b=8'h13 -> slices 00/00, 01/01, 00/00, 10/11, then done at E4 with lt=1, nslc=4. Separately, a=8'h00, b=8'hFF -> lt=1, nslc=1.
- Handshake: start held high continuously with a=8'h30, b=8'h20 -> compares complete with done every 4 cycles. Operand changes applied to a/b while busy=1 do not affect the result (gt=1, nslc=2). Results hold unchanged while start=0.
- Reset mid-RUN: a=8'h01, b=8'h02, rst_n pulsed low at E2 -> all outputs 0 immediately, no done pulse. A new start with a=8'hFF, b=8'h00 then gives gt=1 at E1.
- Comparator consistency: every cycle in RUN, assert cmp_lt/eq/gt is one-hot and busy=~(state IDLE or DONE). Assert done is never high for two consecutive cycles.
